// File: rtl/ej32_fetch_if.sv
// Control bus between the eJ32 fetch/phase sequencer and the execution units:
// memory byte in, branch redirect in, instruction pointer and phase state out.
interface ej32_fetch_if #(
  parameter int ASZ = 17,
  parameter int PSZ = 3
);
  logic           stall;
  logic [7:0]     ram_d;
  logic [ASZ-1:0] br_p;
  logic           br_psel;
  logic [ASZ-1:0] p;
  logic [7:0]     code;
  logic [PSZ-1:0] phase;
  logic           fetch;
  logic           ph_last;

  modport master (
    input  stall, ram_d, br_p, br_psel,
    output p, code, phase, fetch, ph_last
  );

  modport slave (
    output stall, ram_d, br_p, br_psel,
    input  p, code, phase, fetch, ph_last
  );
endinterface

// File: rtl/ej32_fetch.sv
// eJ32 instruction fetch and phase sequencer: owns p, latches opcodes and
// steps the per-instruction phase counter, accepting branch redirects.
module ej32_fetch #(
  parameter int ASZ = 17,
  parameter int PSZ = 3
) (
  input  logic         clk,
  input  logic         rst,
  ej32_fetch_if.master ctl
);

  typedef enum logic {S_FETCH = 1'b0, S_EXEC = 1'b1} state_t;

  state_t         r_state, w_state_nxt;
  logic [ASZ-1:0] r_p, w_p_nxt;
  logic [7:0]     r_code, w_code_nxt;
  logic [PSZ-1:0] r_phase, w_phase_nxt;
  logic [1:0]     r_nb, w_nb_nxt;
  logic [PSZ-1:0] r_nlast, w_nlast_nxt;
  logic [ASZ-1:0] w_p_inc;

  // Operand byte count of an opcode.
  function automatic logic [1:0] dec_nb(input logic [7:0] op);
    logic [1:0] nb;
    nb = 2'd0;
    case (op)
      8'h10, 8'h15, 8'h36: nb = 2'd1;
      8'h11, 8'hA8, 8'hB6: nb = 2'd2;
      default: if (op >= 8'h99 && op <= 8'hA7) nb = 2'd2;
    endcase
    return nb;
  endfunction

  // Index of the final phase: max(1, nb + nx) - 1, nx set only for jsr.
  function automatic logic [PSZ-1:0] dec_nlast(input logic [7:0] op);
    logic [2:0] n;
    n = {1'b0, dec_nb(op)} + ((op == 8'hA8) ? 3'd1 : 3'd0);
    return (n == 3'd0) ? '0 : PSZ'(n - 3'd1);
  endfunction

  assign w_p_inc = r_p + ASZ'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_p     <= '0;
      r_code  <= 8'h00;
      r_phase <= '0;
      r_nb    <= 2'd0;
      r_nlast <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_p     <= w_p_nxt;
      r_code  <= w_code_nxt;
      r_phase <= w_phase_nxt;
      r_nb    <= w_nb_nxt;
      r_nlast <= w_nlast_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_p_nxt     = r_p;
    w_code_nxt  = r_code;
    w_phase_nxt = r_phase;
    w_nb_nxt    = r_nb;
    w_nlast_nxt = r_nlast;
    if (!ctl.stall) begin
      case (r_state)
        S_FETCH: begin
          if (ctl.br_psel) begin
            w_p_nxt = ctl.br_p;
          end else begin
            w_code_nxt  = ctl.ram_d;
            w_nb_nxt    = dec_nb(ctl.ram_d);
            w_nlast_nxt = dec_nlast(ctl.ram_d);
            w_p_nxt     = w_p_inc;
            w_phase_nxt = '0;
            w_state_nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          // A redirect aborts the remaining phases and overrides operand increment.
          if (ctl.br_psel) begin
            w_p_nxt     = ctl.br_p;
            w_phase_nxt = '0;
            w_state_nxt = S_FETCH;
          end else begin
            if (r_phase < PSZ'(r_nb)) w_p_nxt = w_p_inc;
            if (r_phase < r_nlast) begin
              w_phase_nxt = r_phase + PSZ'(1);
            end else begin
              w_phase_nxt = '0;
              w_state_nxt = S_FETCH;
            end
          end
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  assign ctl.p       = r_p;
  assign ctl.code    = r_code;
  assign ctl.phase   = r_phase;
  assign ctl.fetch   = (r_state == S_FETCH);
  assign ctl.ph_last = (r_state == S_EXEC) && (r_phase == r_nlast);

endmodule
